// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed 32-bit multiply / divide beside the ALU.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per clock, followed by a sign-fix cycle that registers the result.
// Optional feature macro: MULTDIV_DIV0_FAST_EN (divide-by-zero finishes at E1).
module multdiv_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        data_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [63:0] r_acc;
  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  logic        r_neg;
  logic        r_is_div;
  logic        r_div0;
  logic        r_ovf;
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_rdy;
  logic        r_busy;

  logic        w_start_mul;
  logic        w_start_div;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [63:0] w_div_shift;
  logic [32:0] w_div_trial;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic        w_mul_exc;
  logic [31:0] w_quo;
  logic [31:0] w_fix_result;
  logic        w_fix_exc;

  // A start is exactly one of the two control pulses; both high is ignored.
  assign w_start_mul = ctrl_MULT & ~ctrl_DIV;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;

  // Two's-complement magnitudes; 0x80000000 maps to 2^31 read as unsigned.
  assign w_mag_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign w_mag_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // One iteration step for each operation, computed from the accumulator.
  always_comb begin
    // Multiply: add multiplicand into the high half when the LSB is set, then shift right.
    w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);
    w_mul_next = {w_mul_sum, r_acc[31:1]};
    // Divide: shift remainder:quotient left, keep the subtraction if it did not borrow.
    w_div_shift = {r_acc[62:0], 1'b0};
    w_div_trial = {1'b0, w_div_shift[63:32]} - {1'b0, r_mag_b};
    w_div_next  = w_div_shift;
    if (!w_div_trial[32]) begin
      w_div_next = {w_div_trial[31:0], w_div_shift[31:1], 1'b1};
    end
  end

  // Sign fix and exception detection applied in the FIX cycle.
  always_comb begin
    w_prod    = r_neg ? (64'd0 - r_acc) : r_acc;
    // Representable iff bits 63..31 of the signed product are all equal.
    w_mul_exc = ~((&w_prod[63:31]) | ~(|w_prod[63:31]));
    w_quo     = r_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    w_fix_result = w_prod[31:0];
    w_fix_exc    = w_mul_exc;
    if (r_is_div) begin
      if (r_div0) begin
        w_fix_result = 32'd0;
        w_fix_exc    = 1'b1;
      end else if (r_ovf) begin
        w_fix_result = 32'h8000_0000;
        w_fix_exc    = 1'b1;
      end else begin
        w_fix_result = w_quo;
        w_fix_exc    = 1'b0;
      end
    end
  end

  // Control FSM: a start in any state (re)launches; RUN iterates 32 times; FIX registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_count  <= 5'd0;
      r_acc    <= 64'd0;
      r_mag_a  <= 32'd0;
      r_mag_b  <= 32'd0;
      r_neg    <= 1'b0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start_mul || w_start_div) begin
        r_count  <= 5'd0;
        r_busy   <= 1'b1;
        r_mag_a  <= w_mag_a;
        r_mag_b  <= w_mag_b;
        r_neg    <= data_operandA[31] ^ data_operandB[31];
        r_is_div <= w_start_div;
        r_div0   <= (data_operandB == 32'd0);
        r_ovf    <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        // Multiply shifts the multiplier out of the low half; divide shifts the dividend in.
        r_acc    <= {32'd0, (w_start_div ? w_mag_a : w_mag_b)};
`ifdef MULTDIV_DIV0_FAST_EN
        if (w_start_div && (data_operandB == 32'd0)) begin
          r_state <= S_FIX;
        end else begin
          r_state <= S_RUN;
        end
`else
        r_state  <= S_RUN;
`endif
      end else begin
        case (r_state)
          S_RUN: begin
            r_acc   <= r_is_div ? w_div_next : w_mul_next;
            r_count <= r_count + 5'd1;
            if (r_count == 5'd31) begin
              r_state <= S_FIX;
            end
          end
          S_FIX: begin
            r_result <= w_fix_result;
            r_exc    <= w_fix_exc;
            r_rdy    <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign data_busy      = r_busy;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed scoreboard bench for multdiv_unit.
// Expected results are queued at stimulus time and popped when RDY pulses.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        data_busy;

  always #5 clock = ~clock;

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

`ifdef MULTDIV_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a start pulse; returns #1 after the start edge E0.
  task automatic start_op(input logic is_div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = !is_div;
    ctrl_DIV      = is_div;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom();
    data_operandB = $urandom();
  endtask

  // Wait (bounded) for RDY, counting edges since E0, and compare against the scoreboard.
  task automatic wait_rdy();
    int   n;
    int   gaps;
    logic found;
    exp_t e;
    n = 0;
    gaps = 0;
    found = 1'b0;
    while (n < 60 && !found) begin
      @(posedge clock);
      #1;
      n++;
      if (data_resultRDY) found = 1'b1;
      else if (!data_busy) gaps++;
    end
    check("rdy_seen", {31'd0, found}, 32'd1);
    if (found) begin
      check("sb_nonempty", sb.size(), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, "_result"}, data_result, e.res);
        check({e.tag, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
        check({e.tag, "_latency"}, n, e.lat);
        check({e.tag, "_busy_at_rdy"}, {31'd0, data_busy}, 32'd0);
        check({e.tag, "_busy_gaps"}, gaps, 32'd0);
        @(posedge clock);
        #1;
        check({e.tag, "_rdy_pulse"}, {31'd0, data_resultRDY}, 32'd0);
        check({e.tag, "_hold"}, data_result, e.res);
        $display("txn %s: result=%h exc=%0d latency=%0d", e.tag, data_result, data_exception, n);
      end
    end
  endtask

  task automatic do_op(input string tag, input logic is_div, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic exc,
                       input int lat);
    exp_t e;
    e.res = res;
    e.exc = exc;
    e.lat = lat;
    e.tag = tag;
    sb.push_back(e);
    start_op(is_div, a, b);
    check({tag, "_busy_e0"}, {31'd0, data_busy}, 32'd1);
    wait_rdy();
  endtask

  initial begin
    int   hits;
    int   busy_hits;
    exp_t e;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, data_busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    do_op("mul_7x-6",      1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 33);
    do_op("mul_ovf",       1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 33);
    do_op("div_-7/2",      1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33);
    do_op("div_min/-1",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
    do_op("div_5/0",       1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1, DIV0_LAT);
    do_op("mul_min_exact", 1'b0, 32'hFFFF_8000,  32'h0001_0000, 32'h8000_0000, 1'b0, 33);
    do_op("mul_min*-1",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
    do_op("mul_-1*-1",     1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
    do_op("div_-100/-7",   1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        1'b0, 33);
    do_op("div_min/1",     1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 33);

    // Restart: mul 3x3 aborted at E10 by div 100/7.
    start_op(1'b0, 32'd3, 32'd3);
    hits = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) hits++;
    end
    e.res = 32'd14;
    e.exc = 1'b0;
    e.lat = 33;
    e.tag = "restart_div";
    sb.push_back(e);
    start_op(1'b1, 32'd100, 32'd7);
    check("restart_no_rdy_pre", hits, 32'd0);
    wait_rdy();

    // Asynchronous reset at E5 of a multiply.
    start_op(1'b0, 32'd5, 32'd5);
    repeat (5) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_result", data_result, 32'd0);
    check("async_rst_exc", {31'd0, data_exception}, 32'd0);
    check("async_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("async_rst_busy", {31'd0, data_busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    hits = 0;
    busy_hits = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) hits++;
      if (data_busy) busy_hits++;
    end
    check("post_rst_no_rdy", hits, 32'd0);
    check("post_rst_no_busy", busy_hits, 32'd0);
    $display("txn reset_mid_mul: rdy_count=%0d busy_count=%0d", hits, busy_hits);

    // Both start pulses on one edge: ignored.
    @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    ctrl_MULT     = 1'b1;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    check("both_busy_e0", {31'd0, data_busy}, 32'd0);
    hits = 0;
    busy_hits = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) hits++;
      if (data_busy) busy_hits++;
    end
    check("both_no_rdy", hits, 32'd0);
    check("both_no_busy", busy_hits, 32'd0);
    $display("txn both_start: rdy_count=%0d busy_count=%0d", hits, busy_hits);

    // A normal op still works afterwards.
    do_op("mul_after", 1'b0, 32'd12, 32'd11, 32'd132, 1'b0, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
